// File: rtl/gray_rd_ptr_sync_if.sv
// Read-side bus of the dual-clock FIFO pointer controller.
// Level_out exists only when GRAY_RD_LEVEL_EN is defined.
interface gray_rd_ptr_sync_if #(
    parameter int COUNTER_WIDTH = 4
);
    logic [COUNTER_WIDTH-1:0] WrGray_in;
    logic                     RdEn_in;
    logic [COUNTER_WIDTH-2:0] RdAddr_out;
    logic [COUNTER_WIDTH-1:0] RdGray_out;
    logic                     RdValid_out;
    logic                     Empty_out;
    logic                     Underflow_out;
`ifdef GRAY_RD_LEVEL_EN
    logic [COUNTER_WIDTH-1:0] Level_out;

    modport master (
        output WrGray_in, RdEn_in,
        input  RdAddr_out, RdGray_out, RdValid_out, Empty_out, Underflow_out, Level_out
    );
    modport slave (
        input  WrGray_in, RdEn_in,
        output RdAddr_out, RdGray_out, RdValid_out, Empty_out, Underflow_out, Level_out
    );
`else
    modport master (
        output WrGray_in, RdEn_in,
        input  RdAddr_out, RdGray_out, RdValid_out, Empty_out, Underflow_out
    );
    modport slave (
        input  WrGray_in, RdEn_in,
        output RdAddr_out, RdGray_out, RdValid_out, Empty_out, Underflow_out
    );
`endif
endinterface

// File: rtl/gray_rd_ptr_sync.sv
// Read-side pointer controller: syncs the writer's Gray pointer, tracks the read
// pointer, flags empty/underflow. GRAY_RD_LEVEL_EN adds the occupancy count Level_out.
module gray_rd_ptr_sync #(
    parameter int COUNTER_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              Clk,
    input  logic              Clear_in,
    gray_rd_ptr_sync_if.slave rd_if
);
    localparam int W = COUNTER_WIDTH;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0] wr_gray_s;
    logic [W-1:0] rd_bin;
    logic [W-1:0] rd_next;
    logic [W-1:0] rd_next_gray;
    logic [W-1:0] rd_gray_q;
    logic         empty_q;
    logic         valid_q;
    logic         under_q;
    logic         accept;

    // Plain flop chain: no logic between stages so each bit settles independently.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rd_if.WrGray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_gray_s    = sync_q[SYNC_STAGES-1];
    assign accept       = rd_if.RdEn_in & ~empty_q;
    assign rd_next      = rd_bin + {{(W-1){1'b0}}, accept};
    assign rd_next_gray = rd_next ^ (rd_next >> 1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make ordering leak into behaviour.
    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            rd_bin    <= '0;
            rd_gray_q <= '0;
            empty_q   <= 1'b1;
            valid_q   <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            rd_bin    <= rd_next;
            rd_gray_q <= rd_next_gray;
            empty_q   <= (wr_gray_s == rd_next_gray);
            valid_q   <= accept;
            under_q   <= rd_if.RdEn_in & empty_q;
        end
    end

`ifdef GRAY_RD_LEVEL_EN
    logic [W-1:0] wr_bin_s;
    logic [W-1:0] level_q;

    // NOTE: give every combinational output a default first so no path can infer a latch.
    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        wr_bin_s = '0;
        for (int i = 0; i < W; i++) begin
            wr_bin_s[i] = ^(wr_gray_s >> i);
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            level_q <= '0;
        end else begin
            level_q <= wr_bin_s - rd_next;
        end
    end

    assign rd_if.Level_out = level_q;
`endif

    assign rd_if.RdAddr_out    = rd_bin[W-2:0];
    assign rd_if.RdGray_out    = rd_gray_q;
    assign rd_if.RdValid_out   = valid_q;
    assign rd_if.Empty_out     = empty_q;
    assign rd_if.Underflow_out = under_q;

endmodule

// File: tb/tb_gray_rd_ptr_sync.sv
// Self-checking bench for gray_rd_ptr_sync: directed scenarios plus randomized
// traffic compared against a counter-and-queue reference model.
module tb_gray_rd_ptr_sync;
    localparam int CW  = 4;
    localparam int SS  = 2;
    localparam int MOD = 1 << CW;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    gray_rd_ptr_sync_if #(.COUNTER_WIDTH(CW)) bus ();

    gray_rd_ptr_sync #(
        .COUNTER_WIDTH(CW),
        .SYNC_STAGES  (SS)
    ) dut (
        .Clk     (clk),
        .Clear_in(clr),
        .rd_if   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: binary counts, a delay queue for the synchronizer.
    int wr_bin = 0;
    int m_rd   = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_valid = 1'b0;
    bit m_under = 1'b0;
    int sync_q[$];
    logic [CW-1:0] gray_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                    4'b0111, 4'b0101, 4'b0100, 4'b1100};

    function automatic logic [CW-1:0] to_gray(int b);
        logic [CW-1:0] v;
        v = CW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic cycle();
        int vis, nxt;
        bit acc;
        bus.WrGray_in = to_gray(wr_bin);
        @(posedge clk);
        if (clr) begin
            sync_q.delete();
            for (int i = 0; i < SS; i++) sync_q.push_back(0);
            m_rd = 0; m_empty = 1'b1; m_valid = 1'b0; m_under = 1'b0; m_level = 0;
        end else begin
            vis     = sync_q[0];
            acc     = bus.RdEn_in && !m_empty;
            nxt     = (m_rd + int'(acc)) % MOD;
            m_under = bus.RdEn_in && m_empty;
            m_valid = acc;
            m_empty = (vis == nxt);
            m_level = (vis - nxt + MOD) % MOD;
            m_rd    = nxt;
            void'(sync_q.pop_front());
            sync_q.push_back(wr_bin);
        end
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1; bus.RdEn_in = 1'b0; wr_bin = 0;
        cycle();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        n_cmp++; if (bus.Empty_out !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", bus.Empty_out); end
        n_cmp++; if (bus.RdGray_out !== 4'b0000) begin n_bad++; $display("FAIL reset_gray got=%b want=0000", bus.RdGray_out); end
        n_cmp++; if (bus.RdAddr_out !== 3'b000) begin n_bad++; $display("FAIL reset_addr got=%b want=000", bus.RdAddr_out); end
        n_cmp++; if (bus.RdValid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", bus.RdValid_out); end
        n_cmp++; if (bus.Underflow_out !== 1'b0) begin n_bad++; $display("FAIL reset_under got=%b want=0", bus.Underflow_out); end
`ifdef GRAY_RD_LEVEL_EN
        n_cmp++; if (bus.Level_out !== 4'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", bus.Level_out); end
`endif
    endtask

    task automatic test_sync_latency();
        wr_bin = 1;
        cycle();
        n_cmp++; if (bus.Empty_out !== 1'b1) begin n_bad++; $display("FAIL lat_edge_n got=%b want=1", bus.Empty_out); end
        cycle();
        n_cmp++; if (bus.Empty_out !== 1'b1) begin n_bad++; $display("FAIL lat_edge_n1 got=%b want=1", bus.Empty_out); end
        cycle();
        n_cmp++; if (bus.Empty_out !== 1'b0) begin n_bad++; $display("FAIL lat_edge_n2 got=%b want=0", bus.Empty_out); end
`ifdef GRAY_RD_LEVEL_EN
        n_cmp++; if (bus.Level_out !== 4'd1) begin n_bad++; $display("FAIL lat_level got=%0d want=1", bus.Level_out); end
`endif
    endtask

    task automatic test_drain();
        while (wr_bin < 8) begin
            wr_bin++;
            cycle();
        end
        repeat (SS + 1) cycle();
        for (int i = 0; i < 8; i++) begin
            bus.RdEn_in = 1'b1;
            n_cmp++; if (bus.RdAddr_out !== 3'(i)) begin n_bad++; $display("FAIL drain_addr[%0d] got=%0d want=%0d", i, bus.RdAddr_out, i); end
            cycle();
            n_cmp++; if (bus.RdGray_out !== gray_tab[i]) begin n_bad++; $display("FAIL drain_gray[%0d] got=%b want=%b", i, bus.RdGray_out, gray_tab[i]); end
            n_cmp++; if (bus.RdValid_out !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, bus.RdValid_out); end
`ifdef GRAY_RD_LEVEL_EN
            n_cmp++; if (bus.Level_out !== 4'(7 - i)) begin n_bad++; $display("FAIL drain_level[%0d] got=%0d want=%0d", i, bus.Level_out, 7 - i); end
`endif
        end
        bus.RdEn_in = 1'b0;
        n_cmp++; if (bus.Empty_out !== 1'b1) begin n_bad++; $display("FAIL drain_empty got=%b want=1", bus.Empty_out); end
        cycle();
        n_cmp++; if (bus.RdValid_out !== 1'b0) begin n_bad++; $display("FAIL drain_valid_end got=%b want=0", bus.RdValid_out); end
    endtask

    task automatic test_underflow();
        bus.RdEn_in = 1'b1;
        cycle();
        bus.RdEn_in = 1'b0;
        n_cmp++; if (bus.Underflow_out !== 1'b1) begin n_bad++; $display("FAIL under_pulse got=%b want=1", bus.Underflow_out); end
        n_cmp++; if (bus.RdValid_out !== 1'b0) begin n_bad++; $display("FAIL under_valid got=%b want=0", bus.RdValid_out); end
        n_cmp++; if (bus.RdGray_out !== 4'b1100) begin n_bad++; $display("FAIL under_gray got=%b want=1100", bus.RdGray_out); end
        cycle();
        n_cmp++; if (bus.Underflow_out !== 1'b0) begin n_bad++; $display("FAIL under_end got=%b want=0", bus.Underflow_out); end
    endtask

    task automatic test_wrap();
        do_clear();
        for (int k = 1; k <= 16; k++) begin
            wr_bin = k % MOD;
            repeat (SS + 1) cycle();
            bus.RdEn_in = 1'b1;
            if (k == 16) begin
                n_cmp++; if (bus.RdGray_out !== 4'b1000) begin n_bad++; $display("FAIL wrap_gray_pre got=%b want=1000", bus.RdGray_out); end
                n_cmp++; if (bus.RdAddr_out !== 3'd7) begin n_bad++; $display("FAIL wrap_addr_pre got=%0d want=7", bus.RdAddr_out); end
            end
            cycle();
            bus.RdEn_in = 1'b0;
            n_cmp++; if (bus.RdValid_out !== 1'b1) begin n_bad++; $display("FAIL wrap_valid[%0d] got=%b want=1", k, bus.RdValid_out); end
            if (k == 16) begin
                n_cmp++; if (bus.RdGray_out !== 4'b0000) begin n_bad++; $display("FAIL wrap_gray got=%b want=0000", bus.RdGray_out); end
                n_cmp++; if (bus.RdAddr_out !== 3'd0) begin n_bad++; $display("FAIL wrap_addr got=%0d want=0", bus.RdAddr_out); end
                n_cmp++; if (bus.Empty_out !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%b want=1", bus.Empty_out); end
`ifdef GRAY_RD_LEVEL_EN
                n_cmp++; if (bus.Level_out !== 4'd0) begin n_bad++; $display("FAIL wrap_level got=%0d want=0", bus.Level_out); end
`endif
            end
        end
    endtask

    task automatic test_clear_mid_read();
        for (int k = 0; k < 5; k++) begin
            wr_bin = (wr_bin + 1) % MOD;
            cycle();
        end
        repeat (SS + 1) cycle();
`ifdef GRAY_RD_LEVEL_EN
        n_cmp++; if (bus.Level_out !== 4'd5) begin n_bad++; $display("FAIL clr_level_pre got=%0d want=5", bus.Level_out); end
`endif
        n_cmp++; if (bus.Empty_out !== 1'b0) begin n_bad++; $display("FAIL clr_empty_pre got=%b want=0", bus.Empty_out); end
        clr = 1'b1; bus.RdEn_in = 1'b1; wr_bin = 0;
        cycle();
        clr = 1'b0; bus.RdEn_in = 1'b0;
        n_cmp++; if (bus.Empty_out !== 1'b1) begin n_bad++; $display("FAIL clr_empty got=%b want=1", bus.Empty_out); end
        n_cmp++; if (bus.RdGray_out !== 4'b0000) begin n_bad++; $display("FAIL clr_gray got=%b want=0000", bus.RdGray_out); end
        n_cmp++; if (bus.RdAddr_out !== 3'd0) begin n_bad++; $display("FAIL clr_addr got=%0d want=0", bus.RdAddr_out); end
        n_cmp++; if (bus.RdValid_out !== 1'b0) begin n_bad++; $display("FAIL clr_valid got=%b want=0", bus.RdValid_out); end
`ifdef GRAY_RD_LEVEL_EN
        n_cmp++; if (bus.Level_out !== 4'd0) begin n_bad++; $display("FAIL clr_level got=%0d want=0", bus.Level_out); end
`endif
        cycle();
        n_cmp++; if (bus.RdValid_out !== 1'b0) begin n_bad++; $display("FAIL clr_valid_next got=%b want=0", bus.RdValid_out); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.RdEn_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && ((wr_bin - m_rd + MOD) % MOD) < 8)
                wr_bin = (wr_bin + 1) % MOD;
            cycle();
            n_cmp++;
            if (bus.RdGray_out !== to_gray(m_rd) || bus.RdAddr_out !== 3'(m_rd)
                || bus.Empty_out !== m_empty || bus.RdValid_out !== m_valid
                || bus.Underflow_out !== m_under) begin
                n_bad++;
                $display("FAIL rand[%0d] got gray=%b addr=%0d e=%b v=%b u=%b want gray=%b addr=%0d e=%b v=%b u=%b",
                         c, bus.RdGray_out, bus.RdAddr_out, bus.Empty_out, bus.RdValid_out, bus.Underflow_out,
                         to_gray(m_rd), m_rd % 8, m_empty, m_valid, m_under);
            end
`ifdef GRAY_RD_LEVEL_EN
            n_cmp++;
            if (bus.Level_out !== 4'(m_level)) begin
                n_bad++;
                $display("FAIL rand_level[%0d] got=%0d want=%0d", c, bus.Level_out, m_level);
            end
`endif
        end
        bus.RdEn_in = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < SS; i++) sync_q.push_back(0);
        bus.RdEn_in   = 1'b0;
        bus.WrGray_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sync_latency();
        test_drain();
        test_underflow();
        test_wrap();
        test_clear_mid_read();
        do_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
